// File: rtl/regfile_mp.sv
// Multi-port register file with sequential clear sweep (busy while sweeping).
// Optional same-cycle write->read bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned N_RD     = 2,
  parameter int unsigned N_WR     = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  output logic                     busy,
  input  logic [N_WR-1:0]          wr_en,
  input  logic [N_WR*ADDR_W-1:0]   wr_addr,
  input  logic [N_WR*DATA_W-1:0]   wr_data,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data
);

  localparam int unsigned       DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] FIRST = (ZERO_REG != 0) ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LAST  = '1;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = ST_READY;
      end
      ST_READY: begin
        if (clear) begin
          state_d = ST_CLEAR;
          cnt_d   = FIRST;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= FIRST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Later ports are written last, so the highest port index wins a collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        mem_q[cnt_q] <= '0;
      end else begin
        for (int unsigned p = 0; p < N_WR; p++) begin
          if (wr_en[p] && !(ZERO_REG != 0 && wr_addr[p*ADDR_W +: ADDR_W] == '0))
            mem_q[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign busy = (state_q == ST_CLEAR);

  for (genvar i = 0; i < N_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] val;

    assign ra = rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      val = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
      for (int unsigned p = 0; p < N_WR; p++) begin
        if (wr_en[p] && wr_addr[p*ADDR_W +: ADDR_W] == ra)
          val = wr_data[p*DATA_W +: DATA_W];
      end
`endif
      if (busy || (ZERO_REG != 0 && ra == '0)) val = '0;
    end

    assign rd_data[i*DATA_W +: DATA_W] = val;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized scoreboard bench for regfile_mp (2 read, 2 write ports, zero entry).
module tb_regfile_mp;

  localparam int unsigned SWEEP = 31;

  logic        clk = 1'b0;
  logic        reset, clear, busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;

  regfile_mp #(
    .DATA_W  (32),
    .ADDR_W  (5),
    .N_RD    (2),
    .N_WR    (2),
    .ZERO_REG(1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .busy   (busy),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        busy;
    logic [31:0] rd0;
    logic [31:0] rd1;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;

  // Reference model: array contents plus remaining busy cycles.
  logic [31:0] m_mem [32];
  int          m_left  = 0;
  bit          m_known = 1'b0;

  function automatic logic [31:0] model_read(input logic [4:0] ra);
    logic [31:0] v;
    if (m_left > 0 || ra == 5'd0) return 32'd0;
    v = m_mem[ra];
`ifdef REGFILE_BYPASS_EN
    if (wr_en[0] && wr_addr[4:0] == ra) v = wr_data[31:0];
    if (wr_en[1] && wr_addr[9:5] == ra) v = wr_data[63:32];
`endif
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp, input int c);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", name, c, got, exp);
  endtask

  task automatic step(input logic rst, input logic clr, input logic [1:0] we,
                      input logic [4:0] wa0, input logic [31:0] wd0,
                      input logic [4:0] wa1, input logic [31:0] wd1,
                      input logic [4:0] ra0, input logic [4:0] ra1);
    exp_t e;
    @(negedge clk);
    reset   = rst;
    clear   = clr;
    wr_en   = we;
    wr_addr = {wa1, wa0};
    wr_data = {wd1, wd0};
    rd_addr = {ra1, ra0};
    #1;
    if (m_known) begin
      e.busy = (m_left > 0);
      e.rd0  = model_read(ra0);
      e.rd1  = model_read(ra1);
      e.cyc  = cyc;
      sb_q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_left  = SWEEP;
      m_known = 1'b1;
      foreach (m_mem[k]) m_mem[k] = 32'd0;
    end else if (m_known) begin
      if (m_left > 0) begin
        m_left--;
      end else begin
        if (we[0] && wa0 != 5'd0) m_mem[wa0] = wd0;
        if (we[1] && wa1 != 5'd0) m_mem[wa1] = wd1;
        if (clr) begin
          // Sweep output is all-zero regardless of this cycle's writes.
          m_left = SWEEP;
          foreach (m_mem[k]) m_mem[k] = 32'd0;
        end
      end
    end
  endtask

  task automatic idle(input int n, input logic [4:0] ra0, input logic [4:0] ra1);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, ra0, ra1);
  endtask

  // Monitor: outputs are combinational, so every driven cycle is a response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("busy", {31'd0, busy}, {31'd0, e.busy}, e.cyc);
        check("rd0", rd_data[31:0], e.rd0, e.cyc);
        check("rd1", rd_data[63:32], e.rd1, e.cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] a;
    reset = 1'b1; clear = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;

    // Reset then full sweep, reading random entries.
    step(1'b1, 1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 5'd2);
    step(1'b1, 1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd4);
    for (int i = 0; i < 33; i++)
      step(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'($urandom), 5'($urandom));
    for (int i = 1; i < 32; i++) idle(1, 5'(i), 5'(32 - i));

    // Fill, then read back on both ports.
    for (int i = 0; i < 32; i++)
      step(1'b0, 1'b0, 2'b01, 5'(i), 32'(i * 10 + 1), 5'd0, 32'd0, 5'(i), 5'(i));
    for (int i = 0; i < 32; i++) idle(1, 5'(i), 5'(31 - i));
    idle(1, 5'd10, 5'd11);

    // Same-address collision and disjoint dual writes.
    step(1'b0, 1'b0, 2'b11, 5'd7, 32'd5, 5'd7, 32'd9, 5'd7, 5'd3);
    step(1'b0, 1'b0, 2'b11, 5'd3, 32'd4, 5'd4, 32'd8, 5'd7, 5'd4);
    idle(1, 5'd3, 5'd4);

    // Runtime clear with writes attempted during the sweep.
    step(1'b0, 1'b0, 2'b01, 5'd5, 32'd55, 5'd0, 32'd0, 5'd5, 5'd6);
    step(1'b0, 1'b1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd5, 5'd6);
    for (int i = 0; i < 32; i++)
      step(1'b0, 1'b0, 2'b10, 5'd0, 32'd0, 5'd6, $urandom, 5'd5, 5'd6);
    idle(2, 5'd5, 5'd6);

    // Reset in the middle of a sweep restarts it.
    step(1'b0, 1'b1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 5'd2);
    idle(10, 5'd1, 5'd2);
    step(1'b1, 1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 5'd2);
    idle(34, 5'd1, 5'd31);

    // Write/read same entry in one cycle.
    step(1'b0, 1'b0, 2'b01, 5'd12, 32'd3, 5'd0, 32'd0, 5'd12, 5'd0);
    step(1'b0, 1'b0, 2'b01, 5'd12, 32'd77, 5'd0, 32'd0, 5'd12, 5'd12);
    step(1'b0, 1'b0, 2'b10, 5'd0, 32'd0, 5'd12, 32'd88, 5'd12, 5'd0);
    idle(1, 5'd12, 5'd12);

    // Random traffic with occasional clear/reset.
    for (int i = 0; i < 600; i++) begin
      a = 5'($urandom_range(0, 7));
      step(($urandom_range(0, 200) == 0), ($urandom_range(0, 60) == 0), 2'($urandom),
           5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), $urandom,
           a, 5'($urandom_range(0, 7)));
    end

    idle(2, 5'd1, 5'd2);
    @(negedge clk);
    #3;
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain got=%0d expected=0", sb_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
